// File: rtl/ifetch_line_responder.sv
// Instruction-fetch responder: one-line buffer serving 32-bit words to the fetch
// stage, refilled by an incrementing burst on a 64-bit AR/R read channel on a miss.
module ifetch_line_responder #(
  parameter int ADDR_WIDTH = 64,
  parameter int BUS_WIDTH  = 64,
  parameter int LINE_BYTES = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] S_R_ADDR,
  input  logic                  S_R_ADDR_VALID,
  output logic [31:0]           S_R_DATA,
  output logic                  S_R_DATA_VALID,
  input  logic                  flush,
  output logic [ADDR_WIDTH-1:0] m_araddr,
  output logic [7:0]            m_arlen,
  output logic                  m_arvalid,
  input  logic                  m_arready,
  input  logic [BUS_WIDTH-1:0]  m_rdata,
  input  logic                  m_rvalid,
  input  logic                  m_rlast,
  output logic                  m_rready
);

  localparam int BEATS  = LINE_BYTES / 8;
  localparam int OFF_W  = $clog2(LINE_BYTES);
  localparam int BEAT_W = OFF_W - 3;
  localparam int TAG_W  = ADDR_WIDTH - OFF_W;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_AR,
    ST_FILL
  } state_t;

  state_t                state_q;
  logic                  line_valid_q;
  logic [TAG_W-1:0]      tag_q;
  logic [TAG_W-1:0]      miss_tag_q;
  logic [BEAT_W-1:0]     beat_cnt_q;
  logic                  flush_pending_q;
  logic                  resp_valid_q;
  logic [ADDR_WIDTH-1:0] resp_addr_q;
  logic [31:0]           resp_data_q;
  logic                  m_arvalid_q;
  logic                  m_rready_q;
  logic [ADDR_WIDTH-1:0] m_araddr_q;

  logic [BUS_WIDTH-1:0]  line_mem [BEATS];

  logic [TAG_W-1:0]      req_tag;
  logic [BEAT_W-1:0]     req_beat;
  logic                  req_half;
  logic                  hit;
  logic [BUS_WIDTH-1:0]  line_word;
  logic [31:0]           sel_word;
  logic                  beat_accept;
  logic                  last_beat;
  logic                  unused_rlast;

  assign req_tag   = S_R_ADDR[ADDR_WIDTH-1:OFF_W];
  assign req_beat  = S_R_ADDR[OFF_W-1:3];
  assign req_half  = S_R_ADDR[2];
  assign hit       = S_R_ADDR_VALID && line_valid_q && (tag_q == req_tag) && !flush;
  assign line_word = line_mem[req_beat];
  assign sel_word  = req_half ? line_word[63:32] : line_word[31:0];

  assign beat_accept = (state_q == ST_FILL) && m_rvalid && m_rready_q;
  assign last_beat   = beat_accept && (beat_cnt_q == LAST_BEAT);

  // Beat count alone terminates the burst, so rlast carries no control meaning.
  assign unused_rlast = m_rlast;

  // Line storage is left unreset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (beat_accept) begin
      line_mem[beat_cnt_q] <= m_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      line_valid_q    <= 1'b0;
      tag_q           <= '0;
      miss_tag_q      <= '0;
      beat_cnt_q      <= '0;
      flush_pending_q <= 1'b0;
      resp_valid_q    <= 1'b0;
      resp_addr_q     <= '0;
      resp_data_q     <= '0;
      m_arvalid_q     <= 1'b0;
      m_rready_q      <= 1'b0;
      m_araddr_q      <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (flush) begin
            line_valid_q <= 1'b0;
            resp_valid_q <= 1'b0;
          end else if (!S_R_ADDR_VALID) begin
            resp_valid_q <= 1'b0;
          end else if (hit) begin
            resp_valid_q <= 1'b1;
            resp_addr_q  <= S_R_ADDR;
            resp_data_q  <= sel_word;
          end else begin
            resp_valid_q <= 1'b0;
            miss_tag_q   <= req_tag;
            m_araddr_q   <= {req_tag, {OFF_W{1'b0}}};
            m_arvalid_q  <= 1'b1;
            state_q      <= ST_AR;
          end
        end

        ST_AR: begin
          resp_valid_q <= 1'b0;
          if (flush) begin
            flush_pending_q <= 1'b1;
          end
          if (m_arready) begin
            m_arvalid_q <= 1'b0;
            m_rready_q  <= 1'b1;
            beat_cnt_q  <= '0;
            state_q     <= ST_FILL;
          end
        end

        ST_FILL: begin
          resp_valid_q <= 1'b0;
          if (flush) begin
            flush_pending_q <= 1'b1;
          end
          if (beat_accept) begin
            beat_cnt_q <= beat_cnt_q + BEAT_W'(1);
          end
          // A flush seen at any point of the burst, including its final beat,
          // leaves the freshly written line invalid.
          if (last_beat) begin
            tag_q           <= miss_tag_q;
            line_valid_q    <= !(flush_pending_q || flush);
            flush_pending_q <= 1'b0;
            m_rready_q      <= 1'b0;
            state_q         <= ST_IDLE;
          end
        end

        default: begin
          state_q     <= ST_IDLE;
          m_arvalid_q <= 1'b0;
          m_rready_q  <= 1'b0;
        end
      endcase
    end
  end

  // Data is only flagged valid while the fetch stage still asks for the exact
  // address it was fetched for, so a changed address never sees a stale word.
  assign S_R_DATA_VALID = resp_valid_q && S_R_ADDR_VALID && (S_R_ADDR == resp_addr_q);
  assign S_R_DATA       = resp_data_q;
  assign m_araddr       = m_araddr_q;
  assign m_arlen        = 8'(BEATS - 1);
  assign m_arvalid      = m_arvalid_q;
  assign m_rready       = m_rready_q;

endmodule

// File: tb/tb_ifetch_line_responder.sv
// Directed bench for ifetch_line_responder: bench-driven memory burst responder,
// inline checks per scenario, one summary line at the end.
module tb_ifetch_line_responder;

  logic        clk;
  logic        reset;
  logic [63:0] S_R_ADDR;
  logic        S_R_ADDR_VALID;
  logic [31:0] S_R_DATA;
  logic        S_R_DATA_VALID;
  logic        flush;
  logic [63:0] m_araddr;
  logic [7:0]  m_arlen;
  logic        m_arvalid;
  logic        m_arready;
  logic [63:0] m_rdata;
  logic        m_rvalid;
  logic        m_rlast;
  logic        m_rready;

  int pass_cnt  = 0;
  int total_cnt = 0;

  ifetch_line_responder #(
    .ADDR_WIDTH(64),
    .BUS_WIDTH (64),
    .LINE_BYTES(64)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .S_R_ADDR      (S_R_ADDR),
    .S_R_ADDR_VALID(S_R_ADDR_VALID),
    .S_R_DATA      (S_R_DATA),
    .S_R_DATA_VALID(S_R_DATA_VALID),
    .flush         (flush),
    .m_araddr      (m_araddr),
    .m_arlen       (m_arlen),
    .m_arvalid     (m_arvalid),
    .m_arready     (m_arready),
    .m_rdata       (m_rdata),
    .m_rvalid      (m_rvalid),
    .m_rlast       (m_rlast),
    .m_rready      (m_rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory side of one burst. Beat k of the line at A carries
  // {base+2k+1, base+2k} with base = A - 0x1000. Optionally changes the fetch
  // address or pulses flush alongside beat evt_beat.
  task automatic serve_burst(input logic [63:0] exp_addr, input int ar_delay,
                             input int evt_beat, input logic [63:0] evt_addr,
                             input bit evt_flush);
    int n;
    bit saw_valid;
    bit unstable;
    logic [31:0] base;
    n = 0;
    saw_valid = 1'b0;
    unstable = 1'b0;
    while (m_arvalid !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    total_cnt++;
    if (m_arvalid !== 1'b1) $display("FAIL ar_wait: m_arvalid=%b expected 1 within 40 cycles", m_arvalid);
    else pass_cnt++;
    total_cnt++;
    if (m_araddr !== exp_addr) $display("FAIL araddr: got %h expected %h", m_araddr, exp_addr);
    else pass_cnt++;
    total_cnt++;
    if (m_arlen !== 8'd7) $display("FAIL arlen: got %0d expected 7", m_arlen);
    else pass_cnt++;
    for (int i = 0; i < ar_delay; i++) begin
      @(negedge clk);
      if (m_arvalid !== 1'b1 || m_araddr !== exp_addr) unstable = 1'b1;
    end
    if (ar_delay > 0) begin
      total_cnt++;
      if (unstable) $display("FAIL ar_hold: arvalid=%b araddr=%h expected 1 and %h held", m_arvalid, m_araddr, exp_addr);
      else pass_cnt++;
    end
    m_arready = 1'b1;
    @(negedge clk);
    m_arready = 1'b0;
    total_cnt++;
    if (m_rready !== 1'b1 || m_arvalid !== 1'b0)
      $display("FAIL ar_handshake: rready=%b arvalid=%b expected 1 and 0", m_rready, m_arvalid);
    else pass_cnt++;
    base = exp_addr[31:0] - 32'h1000;
    for (int k = 0; k < 8; k++) begin
      if (k == evt_beat) begin
        if (evt_flush) flush = 1'b1;
        else S_R_ADDR = evt_addr;
      end
      m_rvalid = 1'b1;
      m_rdata  = {base + 32'(2 * k + 1), base + 32'(2 * k)};
      m_rlast  = (k == 7);
      if (S_R_DATA_VALID !== 1'b0) saw_valid = 1'b1;
      @(negedge clk);
      flush = 1'b0;
    end
    m_rvalid = 1'b0;
    m_rlast  = 1'b0;
    m_rdata  = '0;
    total_cnt++;
    if (saw_valid || m_rready !== 1'b0)
      $display("FAIL fill_quiet: saw_valid=%b rready=%b expected 0 and 0", saw_valid, m_rready);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    bit bad;
    bad = 1'b0;
    reset = 1'b1;
    S_R_ADDR = 64'h1000;
    S_R_ADDR_VALID = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (S_R_DATA_VALID !== 1'b0 || m_arvalid !== 1'b0 || m_rready !== 1'b0) bad = 1'b1;
    end
    total_cnt++;
    if (bad) $display("FAIL reset_outputs: valid=%b arvalid=%b rready=%b expected all 0", S_R_DATA_VALID, m_arvalid, m_rready);
    else pass_cnt++;
    total_cnt++;
    if (S_R_DATA !== 32'h0 || m_araddr !== 64'h0 || m_arlen !== 8'd7)
      $display("FAIL reset_values: data=%h araddr=%h arlen=%0d expected 0 0 7", S_R_DATA, m_araddr, m_arlen);
    else pass_cnt++;
    reset = 1'b0;
    total_cnt++;
    if (m_arvalid !== 1'b0) $display("FAIL release_cycle1: arvalid=%b expected 0", m_arvalid);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (m_arvalid !== 1'b1 || m_araddr !== 64'h1000)
      $display("FAIL release_cycle2: arvalid=%b araddr=%h expected 1 and 1000", m_arvalid, m_araddr);
    else pass_cnt++;
  endtask

  task automatic test_cold_miss();
    // Reset while AR is pending must abandon it.
    reset = 1'b1;
    S_R_ADDR = 64'h1008;
    @(negedge clk);
    total_cnt++;
    if (m_arvalid !== 1'b0) $display("FAIL reset_mid_ar: arvalid=%b expected 0", m_arvalid);
    else pass_cnt++;
    reset = 1'b0;
    serve_burst(64'h1000, 2, -1, 64'h0, 1'b0);
    total_cnt++;
    if (S_R_DATA_VALID !== 1'b0) $display("FAIL cold_after_last: valid=%b expected 0", S_R_DATA_VALID);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (S_R_DATA_VALID !== 1'b1 || S_R_DATA !== 32'h2)
      $display("FAIL cold_data: valid=%b data=%h expected 1 and 00000002", S_R_DATA_VALID, S_R_DATA);
    else pass_cnt++;
  endtask

  task automatic test_sequential_hits();
    logic [63:0] addrs [2];
    logic [31:0] exp_data [2];
    addrs[0] = 64'h100C; exp_data[0] = 32'h3;
    addrs[1] = 64'h1010; exp_data[1] = 32'h4;
    for (int i = 0; i < 2; i++) begin
      S_R_ADDR = addrs[i];
      #1;
      total_cnt++;
      if (S_R_DATA_VALID !== 1'b0) $display("FAIL hit_stale %h: valid=%b expected 0", addrs[i], S_R_DATA_VALID);
      else pass_cnt++;
      @(negedge clk);
      total_cnt++;
      if (S_R_DATA_VALID !== 1'b1 || S_R_DATA !== exp_data[i] || m_arvalid !== 1'b0)
        $display("FAIL hit %h: valid=%b data=%h arvalid=%b expected 1 %h 0",
                 addrs[i], S_R_DATA_VALID, S_R_DATA, m_arvalid, exp_data[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_valid_drop();
    S_R_ADDR_VALID = 1'b0;
    @(negedge clk);
    S_R_ADDR_VALID = 1'b1;
    #1;
    total_cnt++;
    if (S_R_DATA_VALID !== 1'b0) $display("FAIL valid_drop: valid=%b expected 0", S_R_DATA_VALID);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (S_R_DATA_VALID !== 1'b1 || S_R_DATA !== 32'h4)
      $display("FAIL valid_return: valid=%b data=%h expected 1 00000004", S_R_DATA_VALID, S_R_DATA);
    else pass_cnt++;
  endtask

  task automatic test_line_replace();
    S_R_ADDR = 64'h1040;
    serve_burst(64'h1040, 0, -1, 64'h0, 1'b0);
    @(negedge clk);
    total_cnt++;
    if (S_R_DATA_VALID !== 1'b1 || S_R_DATA !== 32'h40)
      $display("FAIL replace_data: valid=%b data=%h expected 1 00000040", S_R_DATA_VALID, S_R_DATA);
    else pass_cnt++;
    S_R_ADDR = 64'h1000;
    serve_burst(64'h1000, 1, -1, 64'h0, 1'b0);
    @(negedge clk);
    total_cnt++;
    if (S_R_DATA_VALID !== 1'b1 || S_R_DATA !== 32'h0)
      $display("FAIL refetch_data: valid=%b data=%h expected 1 00000000", S_R_DATA_VALID, S_R_DATA);
    else pass_cnt++;
  endtask

  task automatic test_addr_change_mid_fill();
    S_R_ADDR = 64'h2000;
    serve_burst(64'h2000, 1, 3, 64'h1004, 1'b0);
    total_cnt++;
    if (S_R_DATA_VALID !== 1'b0) $display("FAIL midfill_valid: valid=%b expected 0", S_R_DATA_VALID);
    else pass_cnt++;
    serve_burst(64'h1000, 0, -1, 64'h0, 1'b0);
    @(negedge clk);
    total_cnt++;
    if (S_R_DATA_VALID !== 1'b1 || S_R_DATA !== 32'h1)
      $display("FAIL midfill_data: valid=%b data=%h expected 1 00000001", S_R_DATA_VALID, S_R_DATA);
    else pass_cnt++;
  endtask

  task automatic test_flush_fill();
    S_R_ADDR = 64'h3000;
    serve_burst(64'h3000, 0, 2, 64'h0, 1'b1);
    total_cnt++;
    if (S_R_DATA_VALID !== 1'b0) $display("FAIL flush_fill_valid: valid=%b expected 0", S_R_DATA_VALID);
    else pass_cnt++;
    serve_burst(64'h3000, 0, -1, 64'h0, 1'b0);
    @(negedge clk);
    total_cnt++;
    if (S_R_DATA_VALID !== 1'b1 || S_R_DATA !== 32'h2000)
      $display("FAIL flush_fill_data: valid=%b data=%h expected 1 00002000", S_R_DATA_VALID, S_R_DATA);
    else pass_cnt++;
  endtask

  task automatic test_flush_idle();
    S_R_ADDR = 64'h3014;
    @(negedge clk);
    total_cnt++;
    if (S_R_DATA_VALID !== 1'b1 || S_R_DATA !== 32'h2005)
      $display("FAIL pre_flush_hit: valid=%b data=%h expected 1 00002005", S_R_DATA_VALID, S_R_DATA);
    else pass_cnt++;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    total_cnt++;
    if (S_R_DATA_VALID !== 1'b0 || m_arvalid !== 1'b0)
      $display("FAIL flush_idle: valid=%b arvalid=%b expected 0 and 0", S_R_DATA_VALID, m_arvalid);
    else pass_cnt++;
    serve_burst(64'h3000, 0, -1, 64'h0, 1'b0);
    @(negedge clk);
    total_cnt++;
    if (S_R_DATA_VALID !== 1'b1 || S_R_DATA !== 32'h2005)
      $display("FAIL post_flush_data: valid=%b data=%h expected 1 00002005", S_R_DATA_VALID, S_R_DATA);
    else pass_cnt++;
  endtask

  initial begin
    reset = 1'b1;
    S_R_ADDR = 64'h0;
    S_R_ADDR_VALID = 1'b0;
    flush = 1'b0;
    m_arready = 1'b0;
    m_rdata = 64'h0;
    m_rvalid = 1'b0;
    m_rlast = 1'b0;
    @(negedge clk);
    test_reset();
    test_cold_miss();
    test_sequential_hits();
    test_valid_drop();
    test_line_replace();
    test_addr_change_mid_fill();
    test_flush_fill();
    test_flush_idle();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d of %0d checks passed", pass_cnt, total_cnt);
    $fatal(1, "watchdog");
  end

endmodule
